phy_tx_ctrl: RTL

Link-state controller and lane scheduler for the PHY transmit path. It brings the link up with a comma training sequence, drives the `idle` select of the recirculator (forward vs. recirculate), and grants the four byte lanes to the serializer in round-robin order. It also selects the control symbol (COM/IDLE) sent when no data is granted. One instance per PHY TX, in the `clk` domain upstream of the serializer muxes.

---
 rtl/phy_tx_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/phy_tx_ctrl.sv
// rtl/phy_tx_ctrl.sv - link-state controller and round-robin lane scheduler for the PHY TX path
module phy_tx_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned IDLE_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] valid_in,
  input  logic       link_ready,
  output logic [1:0] state,
  output logic       idle,
  output logic [1:0] lane_sel,
  output logic       grant_valid,
  output logic [1:0] sym_sel,
  output logic [7:0] burst_count
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  localparam logic [1:0] SYM_DATA = 2'b00;
  localparam logic [1:0] SYM_COM  = 2'b01;
  localparam logic [1:0] SYM_IDLE = 2'b10;

  // Parameters are limited to 1..255, so 8-bit counters always suffice.
  localparam logic [7:0] INIT_TGT = 8'(INIT_CYCLES);
  localparam logic [7:0] HOLD_TGT = 8'(IDLE_HOLD);

  state_t     state_q, state_d;
  logic [7:0] train_q, train_d;
  logic [7:0] hold_q, hold_d;
  logic       idle_d;
  logic [1:0] lane_d;
  logic       grant_d;
  logic [1:0] sym_d;
  logic [7:0] burst_d;

  logic       found;
  logic [1:0] grant_lane;
  logic [1:0] cand;
  logic       link_lost;

  assign state = state_q;

  // Round-robin search starting one past the last granted lane; offset 4 wraps
  // back to the current lane so a lone valid lane is re-granted every cycle.
  // Iterating from the farthest offset down lets the nearest valid lane win.
  always_comb begin
    found      = 1'b0;
    grant_lane = lane_sel;
    cand       = 2'b00;
    for (int i = 4; i >= 1; i--) begin
      cand = lane_sel + 2'(i);
      if (valid_in[cand]) begin
        found      = 1'b1;
        grant_lane = cand;
      end
    end
  end

  // Next-state and next-output logic; link loss overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    train_d   = train_q;
    hold_d    = hold_q;
    idle_d    = idle;
    lane_d    = lane_sel;
    grant_d   = 1'b0;
    sym_d     = sym_sel;
    burst_d   = burst_count;
    link_lost = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
        idle_d  = 1'b0;
        sym_d   = SYM_COM;
        train_d = 8'd0;
        hold_d  = 8'd0;
      end

      ST_INIT: begin
        idle_d = 1'b0;
        sym_d  = SYM_COM;
        hold_d = 8'd0;
        if (!link_ready) begin
          train_d = 8'd0;
        end else if (train_q + 8'd1 == INIT_TGT) begin
          state_d = ST_IDLE;
          train_d = 8'd0;
          idle_d  = 1'b1;
          sym_d   = SYM_IDLE;
        end else begin
          train_d = train_q + 8'd1;
        end
      end

      ST_IDLE: begin
        link_lost = !link_ready;
        idle_d    = 1'b1;
        sym_d     = SYM_IDLE;
        train_d   = 8'd0;
        hold_d    = 8'd0;
        if (|valid_in) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        link_lost = !link_ready;
        idle_d    = 1'b1;
        train_d   = 8'd0;
        if (found) begin
          lane_d  = grant_lane;
          grant_d = 1'b1;
          sym_d   = SYM_DATA;
          hold_d  = 8'd0;
          if (burst_count != 8'hFF) begin
            burst_d = burst_count + 8'd1;
          end
        end else begin
          sym_d = SYM_IDLE;
          if (hold_q + 8'd1 == HOLD_TGT) begin
            state_d = ST_IDLE;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Losing the partner drops straight back to training; the byte total survives.
    if (link_lost) begin
      state_d = ST_INIT;
      idle_d  = 1'b0;
      grant_d = 1'b0;
      sym_d   = SYM_COM;
      train_d = 8'd0;
      hold_d  = 8'd0;
      lane_d  = lane_sel;
      burst_d = burst_count;
    end
  end

  // State, counters and all outputs registered; asynchronous reset to idle-link values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_RESET;
      train_q     <= 8'd0;
      hold_q      <= 8'd0;
      idle        <= 1'b0;
      lane_sel    <= 2'd0;
      grant_valid <= 1'b0;
      sym_sel     <= SYM_COM;
      burst_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      train_q     <= train_d;
      hold_q      <= hold_d;
      idle        <= idle_d;
      lane_sel    <= lane_d;
      grant_valid <= grant_d;
      sym_sel     <= sym_d;
      burst_count <= burst_d;
    end
  end

endmodule
